// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O block sitting beside the 256-word RAM on the
// CPU memory bus. It provides synchronized switch reads, a sticky switch-change
// register that clears on read, an LED register and a 4-digit hex display.
//
// Bus protocol: mem_cmd/mem_addr/write_data are a single-cycle command with no
// handshake. A WRITE takes effect on the next rising clock edge. A READ is
// answered combinationally in the same cycle; io_read_en qualifies
// io_read_data. The top level gates the shared read bus with io_read_en, so
// this block never drives Z.
module mmio_io_ctrl #(
  parameter logic [8:0] SW_ADDR   = 9'h140,
  parameter logic [8:0] EDGE_ADDR = 9'h141,
  parameter logic [8:0] LED_ADDR  = 9'h100,
  parameter logic [8:0] HEX_ADDR  = 9'h120,
  parameter logic [1:0] CMD_READ  = 2'b01,
  parameter logic [1:0] CMD_WRITE = 2'b10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] io_read_data,
  output logic        io_read_en,
  input  logic [9:0]  sw,
  output logic [7:0]  ledr,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  logic [9:0]  sw_s1;
  logic [9:0]  sw_s2;
  logic [7:0]  sw_prev;
  logic [7:0]  edge_reg;
  logic        rd_edge_d;
  logic [15:0] hex_reg;

  logic        rd_edge;
  logic [7:0]  chg;
  logic [7:0]  clr_mask;

  // sw[9:8] pass through the synchronizer but have no address yet.
  logic [1:0]  unused_sw_hi;
  assign unused_sw_hi = sw_s2[9:8];

  // Standard 0-F decode, active-low segments ordered gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Clear only on the first cycle of a read burst, so a held read clears once
  // and edges arriving later in the hold survive for the next read.
  always_comb begin
    rd_edge  = (mem_cmd == CMD_READ) && (mem_addr == EDGE_ADDR);
    chg      = sw_s2[7:0] ^ sw_prev;
    clr_mask = (rd_edge && !rd_edge_d) ? edge_reg : 8'h00;
  end

  // Two-flop switch synchronizer plus sticky edge capture (set wins over clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_prev   <= '0;
      edge_reg  <= '0;
      rd_edge_d <= 1'b0;
    end else begin
      sw_s1     <= sw;
      sw_s2     <= sw_s1;
      sw_prev   <= sw_s2[7:0];
      edge_reg  <= (edge_reg & ~clr_mask) | chg;
      rd_edge_d <= rd_edge;
    end
  end

  // CPU writes to the LED and hex registers; all other write targets ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ledr    <= '0;
      hex_reg <= '0;
    end else if (mem_cmd == CMD_WRITE) begin
      if (mem_addr == LED_ADDR) ledr    <= write_data[7:0];
      if (mem_addr == HEX_ADDR) hex_reg <= write_data;
    end
  end

  // Read decode from registered state; LED is write-only, RAM space never hits.
  always_comb begin
    io_read_en   = 1'b0;
    io_read_data = 16'h0000;
    if (mem_cmd == CMD_READ) begin
      if (mem_addr == SW_ADDR) begin
        io_read_en   = 1'b1;
        io_read_data = {8'h00, sw_s2[7:0]};
      end else if (mem_addr == EDGE_ADDR) begin
        io_read_en   = 1'b1;
        io_read_data = {8'h00, edge_reg};
      end else if (mem_addr == HEX_ADDR) begin
        io_read_en   = 1'b1;
        io_read_data = hex_reg;
      end
    end
  end

  // Display follows hex_reg in the same cycle it changes.
  always_comb begin
    hex0 = seg7(hex_reg[3:0]);
    hex1 = seg7(hex_reg[7:4]);
    hex2 = seg7(hex_reg[11:8]);
    hex3 = seg7(hex_reg[15:12]);
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: table of bus accesses plus hand sequences for switch
// synchronization, edge read-to-clear bursts, hex decode and async reset.
module tb_mmio_io_ctrl;

  localparam logic [8:0] SW_A   = 9'h140;
  localparam logic [8:0] EDGE_A = 9'h141;
  localparam logic [8:0] LED_A  = 9'h100;
  localparam logic [8:0] HEX_A  = 9'h120;
  localparam logic [1:0] RD     = 2'b01;
  localparam logic [1:0] WR     = 2'b10;
  localparam logic [1:0] NONE   = 2'b00;

  logic        clk;
  logic        reset_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] io_read_data;
  logic        io_read_en;
  logic [9:0]  sw;
  logic [7:0]  ledr;
  logic [6:0]  hex0, hex1, hex2, hex3;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] exp_q[$];

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic        exp_en;
    logic [15:0] exp_data;
  } vec_t;

  vec_t       vecs[14];
  logic [6:0] segs[16];

  mmio_io_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_cmd      (mem_cmd),
    .mem_addr     (mem_addr),
    .write_data   (write_data),
    .io_read_data (io_read_data),
    .io_read_en   (io_read_en),
    .sw           (sw),
    .ledr         (ledr),
    .hex0         (hex0),
    .hex1         (hex1),
    .hex2         (hex2),
    .hex3         (hex3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Drive one bus cycle, queue the expected read response, compare mid-cycle,
  // then advance past the next rising edge.
  task automatic step(input string name, input logic [1:0] cmd, input logic [8:0] addr,
                      input logic [15:0] wd, input logic en, input logic [15:0] d);
    logic [16:0] got_exp;
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    exp_q.push_back({en, d});
    @(negedge clk);
    got_exp = exp_q.pop_front();
    check(name, 32'({io_read_en, io_read_data}), 32'(got_exp));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", NONE, EDGE_A, 16'h0000, 1'b0, 16'h0000);
  endtask

  initial begin
    logic [3:0] d4;
    segs[0]  = 7'b1000000; segs[1]  = 7'b1111001; segs[2]  = 7'b0100100; segs[3]  = 7'b0110000;
    segs[4]  = 7'b0011001; segs[5]  = 7'b0010010; segs[6]  = 7'b0000010; segs[7]  = 7'b1111000;
    segs[8]  = 7'b0000000; segs[9]  = 7'b0010000; segs[10] = 7'b0001000; segs[11] = 7'b0000011;
    segs[12] = 7'b1000110; segs[13] = 7'b0100001; segs[14] = 7'b0000110; segs[15] = 7'b0001110;

    vecs[0]  = '{WR,    LED_A,  16'hBEEF, 1'b0, 16'h0000};
    vecs[1]  = '{WR,    HEX_A,  16'h12AF, 1'b0, 16'h0000};
    vecs[2]  = '{RD,    HEX_A,  16'h0000, 1'b1, 16'h12AF};
    vecs[3]  = '{WR,    SW_A,   16'hFFFF, 1'b0, 16'h0000};
    vecs[4]  = '{WR,    9'h0FF, 16'hFFFF, 1'b0, 16'h0000};
    vecs[5]  = '{WR,    EDGE_A, 16'hFFFF, 1'b0, 16'h0000};
    vecs[6]  = '{RD,    LED_A,  16'h0000, 1'b0, 16'h0000};
    vecs[7]  = '{RD,    9'h000, 16'h0000, 1'b0, 16'h0000};
    vecs[8]  = '{2'b11, HEX_A,  16'h0000, 1'b0, 16'h0000};
    vecs[9]  = '{NONE,  LED_A,  16'h0000, 1'b0, 16'h0000};
    vecs[10] = '{RD,    HEX_A,  16'h0000, 1'b1, 16'h12AF};
    vecs[11] = '{RD,    SW_A,   16'h0000, 1'b1, 16'h0001};
    vecs[12] = '{RD,    EDGE_A, 16'h0000, 1'b1, 16'h0000};
    vecs[13] = '{RD,    9'h040, 16'h0000, 1'b0, 16'h0000};

    reset_n    = 1'b0;
    mem_cmd    = NONE;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
    sw         = 10'h000;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    check("rst_ledr", 32'(ledr), 32'h0);
    check("rst_hex", 32'({hex3, hex2, hex1, hex0}), 32'({4{7'b1000000}}));
    step("rst_edge_rd", RD, EDGE_A, 16'h0000, 1'b1, 16'h0000);

    // Switch synchronizer: two-edge latency, bits 9:8 masked
    sw = 10'h0A5;
    step("sw_sync0", RD, SW_A, 16'h0000, 1'b1, 16'h0000);
    step("sw_sync1", RD, SW_A, 16'h0000, 1'b1, 16'h0000);
    step("sw_sync2", RD, SW_A, 16'h0000, 1'b1, 16'h00A5);
    sw = 10'h3A5;
    for (int i = 0; i < 3; i++) step("sw_mask", RD, SW_A, 16'h0000, 1'b1, 16'h00A5);

    // Edges A5 (0->A5) and A5 again (A5->0) accumulate; one read clears them
    sw = 10'h000;
    idle(3);
    step("edge_a5", RD, EDGE_A, 16'h0000, 1'b1, 16'h00A5);
    idle(1);
    step("edge_a5_clr", RD, EDGE_A, 16'h0000, 1'b1, 16'h0000);

    // Edge capture 0->81, then 81->01 lands during a 3-cycle read hold
    sw = 10'h081;
    idle(3);
    sw = 10'h001;
    idle(1);
    step("hold_c1", RD, EDGE_A, 16'h0000, 1'b1, 16'h0081);
    step("hold_c2", RD, EDGE_A, 16'h0000, 1'b1, 16'h0000);
    step("hold_c3", RD, EDGE_A, 16'h0000, 1'b1, 16'h0080);
    idle(1);
    step("edge_after", RD, EDGE_A, 16'h0000, 1'b1, 16'h0080);
    idle(1);
    step("edge_once", RD, EDGE_A, 16'h0000, 1'b1, 16'h0000);

    // Table-driven writes, reads and ignored accesses
    for (int i = 0; i < 14; i++)
      step($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_en, vecs[i].exp_data);
    check("led_beef", 32'(ledr), 32'hEF);
    check("hex_12af", 32'({hex3, hex2, hex1, hex0}),
          32'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));

    // Every hex digit on all four displays
    for (int d = 0; d < 16; d++) begin
      d4 = d[3:0];
      step("hex_wr", WR, HEX_A, {4{d4}}, 1'b0, 16'h0000);
      check($sformatf("hex_seg%0d", d), 32'({hex3, hex2, hex1, hex0}), 32'({4{segs[d]}}));
      step("hex_rd", RD, HEX_A, 16'h0000, 1'b1, {4{d4}});
    end

    // Asynchronous reset in the middle of a write
    step("pre_led", WR, LED_A, 16'h003C, 1'b0, 16'h0000);
    step("pre_hex", WR, HEX_A, 16'h5555, 1'b0, 16'h0000);
    check("pre_led_val", 32'(ledr), 32'h3C);
    sw = 10'h0F1;
    idle(3);
    mem_cmd    = WR;
    mem_addr   = LED_A;
    write_data = 16'h00FF;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ledr", 32'(ledr), 32'h0);
    check("arst_hex", 32'({hex3, hex2, hex1, hex0}), 32'({4{7'b1000000}}));
    check("arst_rd_en", 32'({io_read_en, io_read_data}), 32'h0);
    mem_cmd  = RD;
    mem_addr = EDGE_A;
    #1;
    check("arst_edge", 32'({io_read_en, io_read_data}), 32'h10000);
    mem_addr = HEX_A;
    #1;
    check("arst_hexrd", 32'({io_read_en, io_read_data}), 32'h10000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("post_rst_hex", RD, HEX_A, 16'h0000, 1'b1, 16'h0000);
    check("post_rst_ledr", 32'(ledr), 32'h0);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
